// File: rtl/dmem_sram_like_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_sram_like_bridge_pkg
//   Shared types and constants for the data-side SRAM-to-sram_like bridge:
//   - bridge FSM state encoding
//   - sram_like transfer size codes
//   - MIPS32 kseg0/kseg1 constants and a fixed-segment translation helper,
//     used only when DMEM_ADDR_XLATE_EN is defined
// -----------------------------------------------------------------------------
package dmem_sram_like_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [31:0] KSEG0_BASE  = 32'h8000_0000;
   localparam logic [31:0] KSEG1_BASE  = 32'hA000_0000;
   localparam logic [31:0] KSEG1_LIMIT = 32'hC000_0000;
   localparam logic [31:0] KSEG_MASK   = 32'h1FFF_FFFF;

   // kseg0 and kseg1 are unmapped windows onto the low 512 MB of physical
   // memory; everything else goes out unchanged.
   function automatic logic [31:0] kseg_xlate(input logic [31:0] a);
      logic in_k0;
      logic in_k1;
      in_k0 = (a >= KSEG0_BASE) && (a < KSEG1_BASE);
      in_k1 = (a >= KSEG1_BASE) && (a < KSEG1_LIMIT);
      return (in_k0 || in_k1) ? (a & KSEG_MASK) : a;
   endfunction

endpackage

// File: rtl/dmem_sram_like_bridge_size_enc.sv
// -----------------------------------------------------------------------------
// sram_like_size_enc
//   Combinational mapping of the core's byte-enable / load-size to the
//   sram_like wr flag and size code. Shared with the instruction-side bridge.
//   Ports:
//     i_wen   [3:0]  byte write enables (0 = load)
//     i_rsize [1:0]  load size (0 byte, 1 half, 2 word, 3 treated as word)
//     o_wr           1 = store
//     o_size  [1:0]  sram_like size code
// -----------------------------------------------------------------------------
module sram_like_size_enc
   import dmem_sram_like_bridge_pkg::*;
(
   input  logic [3:0] i_wen,
   input  logic [1:0] i_rsize,
   output logic       o_wr,
   output logic [1:0] o_size
);

   always_comb begin
      o_wr   = |i_wen;
      o_size = SIZE_WORD;
      if (|i_wen) begin
         unique case (i_wen)
            4'b1111:                            o_size = SIZE_WORD;
            4'b0011, 4'b1100:                   o_size = SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = SIZE_BYTE;
            // Irregular patterns go out as a full word; the lane data is
            // already in place and the slave writes all four bytes.
            default:                            o_size = SIZE_WORD;
         endcase
      end else begin
         o_size = (i_rsize == 2'd3) ? SIZE_WORD : i_rsize;
      end
   end

endmodule

// File: rtl/dmem_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// dmem_sram_like_bridge
//   Converts the memory stage's single-cycle SRAM-style data access into an
//   sram_like req/addr_ok/data_ok transaction, stalls the core while it is
//   outstanding and holds load data until the pipeline advances.
//   Optional feature: define DMEM_ADDR_XLATE_EN to apply fixed MIPS32
//   kseg0/kseg1 translation to the bus address at latch time.
//   Ports:
//     clk, rst                  clock, async active-high reset
//     cpu_en/wen/rsize/addr/wdata  core access
//     cpu_flush, cpu_adv        flush of the M-stage instr, pipeline advance
//     cpu_rdata, cpu_stall      load data and stall request back to the core
//     req/wr/size/addr/wdata    sram_like request (registered)
//     addr_ok, data_ok, rdata   sram_like responses
// -----------------------------------------------------------------------------
module dmem_sram_like_bridge
   import dmem_sram_like_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_en,
   input  logic [3:0]        cpu_wen,
   input  logic [1:0]        cpu_rsize,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_flush,
   input  logic              cpu_adv,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              req,
   output logic              wr,
   output logic [1:0]        size,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic              addr_ok,
   input  logic              data_ok,
   input  logic [DATA_W-1:0] rdata
);

   state_t            r_state;
   state_t            w_next;
   logic              r_req;
   logic              r_wr;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_discard;

   logic              w_wr;
   logic [1:0]        w_size;
   logic [ADDR_W-1:0] w_addr;
   logic              w_accept;
   logic              w_drop;
   logic              w_stall;

   sram_like_size_enc u_size_enc (
      .i_wen   (cpu_wen),
      .i_rsize (cpu_rsize),
      .o_wr    (w_wr),
      .o_size  (w_size)
   );

`ifdef DMEM_ADDR_XLATE_EN
   assign w_addr = kseg_xlate(cpu_addr);
`else
   assign w_addr = cpu_addr;
`endif

   assign w_accept = (r_state == ST_IDLE) && cpu_en && !cpu_flush;
   // A flush arriving in the data_ok cycle itself still drops the data.
   assign w_drop   = r_discard || cpu_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_stall = cpu_en && !cpu_flush;
            if (w_accept) w_next = ST_REQ;
         end
         ST_REQ: begin
            // data_ok is never valid in the acceptance cycle, so it is ignored
            w_stall = 1'b1;
            if (addr_ok) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_stall = 1'b1;
            if (data_ok) w_next = w_drop ? ST_IDLE : ST_HOLD;
         end
         ST_HOLD: begin
            if (cpu_adv || cpu_flush) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Gated so the stall drops the instant reset is asserted, even if the
   // core is still presenting an access.
   assign cpu_stall = w_stall && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req   <= 1'b0;
         r_wr    <= 1'b0;
         r_size  <= SIZE_BYTE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_req   <= 1'b1;
            r_wr    <= w_wr;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_wdata <= cpu_wdata;
         end else if ((r_state == ST_REQ) && addr_ok) begin
            r_req <= 1'b0;
         end
         if ((r_state == ST_WAIT) && data_ok && !r_wr && !w_drop)
            r_rdata <= rdata;
      end
   end

   // The bus transfer cannot be cancelled; a flush only marks its result
   // for discard once it completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_discard <= 1'b0;
      end else if ((r_state == ST_WAIT) && data_ok) begin
         r_discard <= 1'b0;
      end else if (((r_state == ST_REQ) || (r_state == ST_WAIT)) && cpu_flush) begin
         r_discard <= 1'b1;
      end
   end

   assign req       = r_req;
   assign wr        = r_wr;
   assign size      = r_size;
   assign addr      = r_addr;
   assign wdata     = r_wdata;
   assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
module tb_dmem_sram_like_bridge;

   logic        clk;
   logic        rst;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [1:0]  cpu_rsize;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_flush;
   logic        cpu_adv;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int n_cmp = 0;
   int n_err = 0;

   dmem_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_en    (cpu_en),
      .cpu_wen   (cpu_wen),
      .cpu_rsize (cpu_rsize),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_flush (cpu_flush),
      .cpu_adv   (cpu_adv),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .req       (req),
      .wr        (wr),
      .size      (size),
      .addr      (addr),
      .wdata     (wdata),
      .addr_ok   (addr_ok),
      .data_ok   (data_ok),
      .rdata     (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] xl_exp;
`ifdef DMEM_ADDR_XLATE_EN
      xl_exp = 32'h1FC0_0010;
`else
      xl_exp = 32'hBFC0_0010;
`endif
      rst = 1'b1; cpu_en = 0; cpu_wen = 0; cpu_rsize = 0; cpu_addr = 0;
      cpu_wdata = 0; cpu_flush = 0; cpu_adv = 0; addr_ok = 0; data_ok = 0; rdata = 0;

      // ---- reset state
      @(negedge clk);
      chk("rst_req", req, 0); chk("rst_stall", cpu_stall, 0);
      chk("rst_rdata", cpu_rdata, 0); chk("rst_addr", addr, 0);
      chk("rst_size", size, 0); chk("rst_wr", wr, 0); chk("rst_wdata", wdata, 0);
      rst = 1'b0;

      // ---- word load, addr_ok first REQ cycle, data_ok next
      @(negedge clk);
      cpu_en = 1; cpu_wen = 4'b0000; cpu_rsize = 2; cpu_addr = 32'h0000_1000;
      #1 chk("ld_idle_stall", cpu_stall, 1); chk("ld_idle_req", req, 0);
      @(negedge clk);
      chk("ld_req", req, 1); chk("ld_size", size, 2); chk("ld_wr", wr, 0);
      chk("ld_addr", addr, 32'h0000_1000); chk("ld_req_stall", cpu_stall, 1);
      addr_ok = 1;
      @(negedge clk);
      addr_ok = 0;
      #1 chk("ld_wait_req", req, 0); chk("ld_wait_stall", cpu_stall, 1);
      data_ok = 1; rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      data_ok = 0; rdata = 32'h0;
      #1 chk("ld_hold_stall", cpu_stall, 0); chk("ld_hold_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("ld_hold_req", req, 0);
      cpu_adv = 1;
      @(negedge clk);
      cpu_adv = 0; cpu_en = 0;
      #1 chk("ld_idle2_stall", cpu_stall, 0); chk("ld_idle2_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // ---- byte store, addr_ok delayed 4 cycles
      cpu_en = 1; cpu_wen = 4'b0100; cpu_addr = 32'h0000_2002; cpu_wdata = 32'h00AB_0000;
      #1 chk("st_idle_stall", cpu_stall, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("st_req", req, 1); chk("st_addr", addr, 32'h0000_2002);
         chk("st_wdata", wdata, 32'h00AB_0000); chk("st_size", size, 0);
         chk("st_wr", wr, 1); chk("st_req_stall", cpu_stall, 1);
         if (i == 4) addr_ok = 1;
      end
      @(negedge clk);
      addr_ok = 0;
      #1 chk("st_wait_req", req, 0); chk("st_wait_stall", cpu_stall, 1);
      @(negedge clk);
      chk("st_wait2_stall", cpu_stall, 1);
      data_ok = 1; rdata = 32'h1234_5678;
      @(negedge clk);
      data_ok = 0;
      #1 chk("st_hold_stall", cpu_stall, 0); chk("st_hold_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // ---- external stall in HOLD: no re-issue, data stable
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("xs_stall", cpu_stall, 0); chk("xs_req", req, 0);
         chk("xs_rdata", cpu_rdata, 32'hDEAD_BEEF);
      end
      cpu_adv = 1;
      @(negedge clk);
      cpu_adv = 0;

      // ---- flush in WAIT; first check also shows HOLD has been left
      cpu_en = 1; cpu_wen = 0; cpu_rsize = 0; cpu_addr = 32'h0000_3000;
      #1 chk("fl_idle_stall", cpu_stall, 1);
      @(negedge clk);
      chk("fl_req", req, 1); chk("fl_size", size, 0);
      addr_ok = 1;
      @(negedge clk);
      addr_ok = 0; cpu_flush = 1;
      #1 chk("fl_wait_stall", cpu_stall, 1);
      @(negedge clk);
      cpu_flush = 0; cpu_en = 0;
      #1 chk("fl_wait2_stall", cpu_stall, 1); chk("fl_wait2_req", req, 0);
      data_ok = 1; rdata = 32'hCAFE_F00D;
      @(negedge clk);
      data_ok = 0;
      #1 chk("fl_end_stall", cpu_stall, 0); chk("fl_end_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // ---- segment load (rsize 3 -> word); IDLE, not HOLD, so stall rises
      cpu_en = 1; cpu_wen = 0; cpu_rsize = 3; cpu_addr = 32'hBFC0_0010;
      #1 chk("xl_idle_stall", cpu_stall, 1);
      @(negedge clk);
      chk("xl_req", req, 1); chk("xl_addr", addr, xl_exp); chk("xl_size", size, 2);

      // ---- async reset mid-cycle while in REQ
      #2 rst = 1;
      #1 chk("ar_req", req, 0); chk("ar_stall", cpu_stall, 0); chk("ar_addr", addr, 0);
      chk("ar_size", size, 0); chk("ar_wr", wr, 0); chk("ar_wdata", wdata, 0);
      chk("ar_rdata", cpu_rdata, 0);
      cpu_en = 0;
      @(negedge clk);
      rst = 0;
      #1 chk("ar_post_req", req, 0); chk("ar_post_stall", cpu_stall, 0);

      // ---- half store with data_ok alongside addr_ok (must be ignored)
      cpu_en = 1; cpu_wen = 4'b1100; cpu_addr = 32'h0000_4002; cpu_wdata = 32'h1234_0000;
      @(negedge clk);
      chk("hs_req", req, 1); chk("hs_size", size, 1); chk("hs_wr", wr, 1);
      chk("hs_wdata", wdata, 32'h1234_0000);
      addr_ok = 1; data_ok = 1; rdata = 32'h5555_5555;
      @(negedge clk);
      addr_ok = 0; data_ok = 0;
      #1 chk("hs_wait_stall", cpu_stall, 1); chk("hs_wait_req", req, 0);
      data_ok = 1;
      @(negedge clk);
      data_ok = 0;
      #1 chk("hs_hold_stall", cpu_stall, 0); chk("hs_hold_rdata", cpu_rdata, 0);
      cpu_adv = 1;
      @(negedge clk);
      cpu_adv = 0;

      // ---- irregular byte enable goes out as word
      cpu_en = 1; cpu_wen = 4'b0101; cpu_addr = 32'h0000_5000;
      @(negedge clk);
      chk("ir_size", size, 2); chk("ir_wr", wr, 1);
      addr_ok = 1;
      @(negedge clk);
      addr_ok = 0; data_ok = 1;
      @(negedge clk);
      data_ok = 0; cpu_adv = 1;
      #1 chk("ir_hold_stall", cpu_stall, 0);
      @(negedge clk);
      cpu_adv = 0; cpu_en = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
